// File: rtl/line_track_pkg.sv
// Shared widths, image defaults and FSM state encoding
// for the line centroid tracker.
package line_track_pkg;

    localparam int IMG_W_DEF  = 320;
    localparam int IMG_H_DEF  = 240;
    localparam int ADDR_W     = 17;
    localparam int COL_W      = 9;
    localparam int ROW_W      = 8;
    localparam int SUM_W      = 23;
    localparam int CNT_W      = 15;
    localparam int CEN_W      = 9;
    localparam int DIV_CYCLES = 23;
    localparam int DIV_CNT_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_STORE,
        ST_DONE
    } lt_state_e;

endpackage

// File: rtl/line_track_divider.sv
// Restoring divider, one quotient bit per cycle, fixed DIV_CYCLES latency.
// done_o flags the final iteration; quotient_o is final the following cycle.
module line_track_divider
    import line_track_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [SUM_W-1:0] dividend_i,
    input  logic [SUM_W-1:0] divisor_i,
    output logic             done_o,
    output logic [CEN_W-1:0] quotient_o
);

    logic [SUM_W-1:0]     quo_q, quo_d;
    logic [SUM_W-1:0]     rem_q, rem_d;
    logic [SUM_W-1:0]     den_q;
    logic [DIV_CNT_W-1:0] cnt_q;
    logic                 run_q;
    logic [SUM_W:0]       shl;

    always_comb begin
        shl = {rem_q, quo_q[SUM_W-1]};
        if (shl >= {1'b0, den_q}) begin
            rem_d = SUM_W'(shl - {1'b0, den_q});
            quo_d = {quo_q[SUM_W-2:0], 1'b1};
        end else begin
            rem_d = shl[SUM_W-1:0];
            quo_d = {quo_q[SUM_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            den_q <= divisor_i;
            cnt_q <= DIV_CNT_W'(DIV_CYCLES);
            run_q <= 1'b1;
        end else if (run_q) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - DIV_CNT_W'(1);
            if (cnt_q == DIV_CNT_W'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o = run_q && (cnt_q == DIV_CNT_W'(1));

    // Centroid is a column index, so only the low bits are meaningful
    assign quotient_o = quo_q[CEN_W-1:0];

endmodule

// File: rtl/line_centroid_tracker.sv
// Per-band x centroid of thresholded line pixels, divided after each frame.
// Define LINE_TRACK_MINCOUNT_EN to require MIN_PIXELS hits for a valid band.
module line_centroid_tracker
    import line_track_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int BANDS      = 4,
    parameter int MIN_PIXELS = 16
) (
    input  logic                   cam_pclk,
    input  logic                   nreset,
    input  logic                   pix_valid,
    input  logic                   pix_bit,
    input  logic [ADDR_W-1:0]      pix_addr,
    input  logic                   frame_done,
    output logic [BANDS*CEN_W-1:0] centroid_x,
    output logic [BANDS-1:0]       band_valid,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   overrun
);

    localparam int BAND_H = IMG_H / BANDS;
    localparam int BW     = (BANDS > 1) ? $clog2(BANDS) : 1;

    logic [COL_W-1:0]       col_q, col_d, col_eff;
    logic [ROW_W-1:0]       row_q, row_d, row_eff;
    logic [SUM_W-1:0]       sum_q      [BANDS];
    logic [SUM_W-1:0]       sum_d      [BANDS];
    logic [SUM_W-1:0]       snap_sum_q [BANDS];
    logic [CNT_W-1:0]       cnt_q      [BANDS];
    logic [CNT_W-1:0]       cnt_d      [BANDS];
    logic [CNT_W-1:0]       snap_cnt_q [BANDS];
    logic [CEN_W-1:0]       cen_q      [BANDS];
    logic [CEN_W-1:0]       cen_d      [BANDS];
    logic [BANDS-1:0]       vld_q, vld_d;
    lt_state_e              state_q, state_d;
    logic [BW-1:0]          band_q, band_d;
    logic [BANDS*CEN_W-1:0] cx_q;
    logic [BANDS-1:0]       bv_q;
    logic                   rv_q, ov_q;
    logic                   busy_w, take, drop, hit;
    logic                   div_start, div_done;
    logic [CEN_W-1:0]       div_quo;

    assign busy_w = (state_q != ST_IDLE);
    assign take   = frame_done && !busy_w;
    assign drop   = frame_done && busy_w;

    // Address zero re-anchors the raster so a lost strobe cannot skew a frame
    always_comb begin
        col_eff = (pix_addr == '0) ? '0 : col_q;
        row_eff = (pix_addr == '0) ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (pix_valid) begin
            if (col_eff == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = row_eff + ROW_W'(1);
            end else begin
                col_d = col_eff + COL_W'(1);
                row_d = row_eff;
            end
        end
        hit = pix_valid && pix_bit && (int'(row_eff) < IMG_H);
        for (int b = 0; b < BANDS; b++) begin
            sum_d[b] = sum_q[b];
            cnt_d[b] = cnt_q[b];
            if (hit && int'(row_eff) >= b * BAND_H
                    && int'(row_eff) < (b + 1) * BAND_H) begin
                sum_d[b] = sum_q[b] + SUM_W'(col_eff);
                cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            col_q <= '0;
            row_q <= '0;
            for (int b = 0; b < BANDS; b++) begin
                sum_q[b]      <= '0;
                cnt_q[b]      <= '0;
                snap_sum_q[b] <= '0;
                snap_cnt_q[b] <= '0;
            end
        end else if (frame_done) begin
            col_q <= '0;
            row_q <= '0;
            for (int b = 0; b < BANDS; b++) begin
                sum_q[b] <= '0;
                cnt_q[b] <= '0;
                if (take) begin
                    snap_sum_q[b] <= sum_d[b];
                    snap_cnt_q[b] <= cnt_d[b];
                end
            end
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            for (int b = 0; b < BANDS; b++) begin
                sum_q[b] <= sum_d[b];
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    line_track_divider u_div (
        .clk        (cam_pclk),
        .rst_n      (nreset),
        .start_i    (div_start),
        .dividend_i (snap_sum_q[band_q]),
        .divisor_i  (SUM_W'(snap_cnt_q[band_q])),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    always_comb begin
        state_d   = state_q;
        band_d    = band_q;
        div_start = 1'b0;
        vld_d     = vld_q;
        for (int b = 0; b < BANDS; b++) begin
            cen_d[b] = cen_q[b];
        end
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_LOAD;
                    band_d  = '0;
                end
            end
            ST_LOAD: begin
                div_start = 1'b1;
                state_d   = ST_DIV;
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                cen_d[band_q] = (snap_cnt_q[band_q] == '0) ? '0 : div_quo;
`ifdef LINE_TRACK_MINCOUNT_EN
                vld_d[band_q] = int'(snap_cnt_q[band_q]) >= MIN_PIXELS;
`else
                vld_d[band_q] = snap_cnt_q[band_q] != '0;
`endif
                if (band_q == BW'(BANDS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    band_d  = band_q + BW'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            band_q  <= '0;
            vld_q   <= '0;
            cx_q    <= '0;
            bv_q    <= '0;
            rv_q    <= 1'b0;
            ov_q    <= 1'b0;
            for (int b = 0; b < BANDS; b++) begin
                cen_q[b] <= '0;
            end
        end else begin
            state_q <= state_d;
            band_q  <= band_d;
            vld_q   <= vld_d;
            rv_q    <= (state_d == ST_DONE);
            ov_q    <= drop;
            for (int b = 0; b < BANDS; b++) begin
                cen_q[b] <= cen_d[b];
            end
            // Publish all bands together as the sequence enters DONE
            if (state_q == ST_STORE && state_d == ST_DONE) begin
                for (int b = 0; b < BANDS; b++) begin
                    cx_q[b*CEN_W +: CEN_W] <= cen_d[b];
                end
                bv_q <= vld_d;
            end
        end
    end

    assign centroid_x   = cx_q;
    assign band_valid   = bv_q;
    assign result_valid = rv_q;
    assign busy         = busy_w;
    assign overrun      = ov_q;

endmodule

// File: tb/tb_line_centroid_tracker.sv
// Scoreboard bench for line_centroid_tracker on a reduced 40x24 image.
// Pixels are generated at known (x,y); expected centroids come from plain sums.
module tb_line_centroid_tracker;

    localparam int W   = 40;
    localparam int H   = 24;
    localparam int NB  = 4;
    localparam int BH  = H / NB;
    localparam int MP  = 16;
    localparam int CW  = 9;
    localparam int LAT = NB * 25 + 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          pv    = 1'b0;
    logic          pb    = 1'b0;
    logic          fd    = 1'b0;
    logic [16:0]   pa    = '0;
    logic [NB*CW-1:0] cx;
    logic [NB-1:0] bv;
    logic          rv, bsy, ov;

    line_centroid_tracker #(
        .IMG_W      (W),
        .IMG_H      (H),
        .BANDS      (NB),
        .MIN_PIXELS (MP)
    ) dut (
        .cam_pclk     (clk),
        .nreset       (rst_n),
        .pix_valid    (pv),
        .pix_bit      (pb),
        .pix_addr     (pa),
        .frame_done   (fd),
        .centroid_x   (cx),
        .band_valid   (bv),
        .result_valid (rv),
        .busy         (bsy),
        .overrun      (ov)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               c;
        logic [NB*CW-1:0] cx;
        logic [NB-1:0]    bv;
    } res_t;

    res_t rq[$];
    int   oq[$];
    int   checks = 0;
    int   errs   = 0;
    int   bf     = -1;
    int   bt     = -2;
    int   pos    = 0;
    longint msum[NB];
    int     mcnt[NB];
    logic [NB*CW-1:0] hold_cx = '0;
    logic [NB-1:0]    hold_bv = '0;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        res_t r;
        if (rst_n) begin
            chk("busy", 64'(bsy), 64'(cyc >= bf && cyc <= bt));
            if (rv) begin
                if (rq.size() == 0) begin
                    chk("unexpected_result", 64'(rv), 64'd0);
                end else begin
                    r = rq.pop_front();
                    chk("result_cycle", 64'(cyc), 64'(r.c));
                    chk("centroid_x", 64'(cx), 64'(r.cx));
                    chk("band_valid", 64'(bv), 64'(r.bv));
                    hold_cx = r.cx;
                    hold_bv = r.bv;
                end
            end else begin
                chk("hold_centroid_x", 64'(cx), 64'(hold_cx));
                chk("hold_band_valid", 64'(bv), 64'(hold_bv));
                if (rq.size() > 0 && cyc > rq[0].c) begin
                    chk("missing_result", 64'(rv), 64'd1);
                    void'(rq.pop_front());
                end
            end
            if (ov) begin
                if (oq.size() == 0) begin
                    chk("unexpected_overrun", 64'(ov), 64'd0);
                end else begin
                    chk("overrun_cycle", 64'(cyc), 64'(oq.pop_front()));
                end
            end else if (oq.size() > 0 && cyc > oq[0]) begin
                chk("missing_overrun", 64'(ov), 64'd1);
                void'(oq.pop_front());
            end
        end
    end

    task automatic clear_model();
        for (int b = 0; b < NB; b++) begin
            msum[b] = 0;
            mcnt[b] = 0;
        end
        pos = 0;
    endtask

    task automatic drive(bit v, bit b, int a, bit f);
        @(posedge clk);
        #1;
        pv = v;
        pb = b;
        pa = 17'(a);
        fd = f;
    endtask

    task automatic model_px(bit b);
        int x, y;
        x = pos % W;
        y = pos / W;
        if (b && y < H) begin
            msum[y / BH] += x;
            mcnt[y / BH]++;
        end
        pos++;
    endtask

    function automatic bit pick(int kind, int dens);
        int x, y;
        x = pos % W;
        y = pos / W;
        case (kind)
            1: return (y < BH) && (x >= 10) && (x <= 19);
            2: return 1'b0;
            3: return ((y / BH) != 2) && ($urandom_range(99) < dens);
            default: return $urandom_range(99) < dens;
        endcase
    endfunction

    task automatic px(bit b, bit gaps);
        if (gaps && $urandom_range(7) == 0) begin
            drive(1'b0, 1'($urandom), int'($urandom_range(131071)), 1'b0);
        end
        drive(1'b1, b, pos, 1'b0);
        model_px(b);
    endtask

    task automatic stream(int kind, int dens, int n);
        for (int i = 0; i < n; i++) begin
            px(pick(kind, dens), 1'b1);
        end
    endtask

    task automatic frame_end(bit with_px, bit b);
        res_t r;
        if (with_px) begin
            drive(1'b1, b, pos, 1'b1);
            model_px(b);
        end else begin
            drive(1'b0, 1'b0, 0, 1'b1);
        end
        if (cyc >= bf && cyc <= bt) begin
            oq.push_back(cyc + 1);
        end else begin
            r.c = cyc + LAT;
            for (int k = 0; k < NB; k++) begin
                if (mcnt[k] == 0) begin
                    r.cx[k*CW +: CW] = '0;
                    r.bv[k] = 1'b0;
                end else begin
                    r.cx[k*CW +: CW] = CW'((msum[k] / mcnt[k]) % 512);
`ifdef LINE_TRACK_MINCOUNT_EN
                    r.bv[k] = (mcnt[k] >= MP);
`else
                    r.bv[k] = 1'b1;
`endif
                end
            end
            rq.push_back(r);
            bf = cyc + 1;
            bt = cyc + LAT;
        end
        clear_model();
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        drive(1'b0, 1'b0, 0, 1'b0);
        while ((rq.size() > 0 || oq.size() > 0 || cyc <= bt) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) begin
            chk("wait_timeout", 64'(rq.size() + oq.size()), 64'd0);
        end
    endtask

    task automatic do_reset(int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        pv = 1'b0;
        pb = 1'b0;
        fd = 1'b0;
        pa = '0;
        rq.delete();
        oq.delete();
        bf = -1;
        bt = -2;
        hold_cx = '0;
        hold_bv = '0;
        clear_model();
        @(negedge clk);
        chk("rst_centroid_x", 64'(cx), 64'd0);
        chk("rst_band_valid", 64'(bv), 64'd0);
        chk("rst_result_valid", 64'(rv), 64'd0);
        chk("rst_busy", 64'(bsy), 64'd0);
        chk("rst_overrun", 64'(ov), 64'd0);
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        clear_model();
        do_reset(3);

        // band0 stripe at cols 10..19 on every band0 row
        stream(1, 0, W * H);
        frame_end(1'b0, 1'b0);
        wait_done();

        // single pixel at the last column of the last row
        stream(2, 0, W * H - 1);
        px(1'b1, 1'b0);
        frame_end(1'b0, 1'b0);
        wait_done();

        // second frame_done 50 cycles into the divide
        stream(0, 30, W * H);
        frame_end(1'b0, 1'b0);
        for (int i = 0; i < 49; i++) begin
            px(1'($urandom_range(1)), 1'b0);
        end
        frame_end(1'b0, 1'b0);
        wait_done();

        // reset 40 cycles into the divide, then a clean frame
        stream(0, 25, W * H);
        frame_end(1'b0, 1'b0);
        idle(39);
        do_reset(2);
        stream(0, 40, W * H);
        frame_end(1'b0, 1'b0);
        wait_done();

        // address zero injected mid-row
        stream(0, 35, 5 * W + 17);
        pos = 0;
        px(1'b1, 1'b0);
        stream(0, 35, W * H - 1);
        frame_end(1'b0, 1'b0);
        wait_done();

        // pixel coincident with frame_done, band2 otherwise empty
        stream(3, 40, 14 * W + 20);
        frame_end(1'b1, 1'b1);
        wait_done();
        stream(0, 20, W * H);
        frame_end(1'b0, 1'b0);
        wait_done();

        // frame_done in the DONE cycle is dropped
        stream(0, 50, W * H);
        frame_end(1'b0, 1'b0);
        idle(100);
        frame_end(1'b0, 1'b0);
        wait_done();

        // frame_done one cycle after DONE is accepted
        stream(0, 15, W * H);
        frame_end(1'b0, 1'b0);
        idle(101);
        frame_end(1'b0, 1'b0);
        wait_done();

        // random frames with overflow rows and coincident pixels
        for (int f = 0; f < 4; f++) begin
            stream(0, int'($urandom_range(5, 90)),
                   W * H + int'($urandom_range(0, 2 * W)));
            frame_end(1'($urandom_range(1)), 1'($urandom_range(1)));
            wait_done();
        end

        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

    initial begin
        #3000000;
        errs++;
        $display("FAIL watchdog: got no completion expected finish by cycle %0d",
                 cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule

// File: doc/line_centroid_tracker.md
LINE_CENTROID_TRACKER -- requirements
Module: line_centroid_tracker

Interface
REQ-001 SHALL have parameters:
- IMG_W, 320, pixels per row.
- IMG_H, 240, rows per frame.
- BANDS, 4, horizontal row bands; IMG_H divisible by BANDS.
- MIN_PIXELS, 16, minimum set pixels for a band to be valid (used only under LINE_TRACK_MINCOUNT_EN).

REQ-002 SHALL have ports:
- cam_pclk, input, 1, sole clock (camera pixel clock).
- nreset, input, 1, asynchronous active-low reset.
- pix_valid, input, 1, thresholded pixel strobe.
- pix_bit, input, 1, 1 = pixel above threshold (line).
- pix_addr, input, 17, linear pixel address (row*IMG_W+col).
- frame_done, input, 1, single-cycle end-of-frame strobe.
- centroid_x, output, BANDS*9, per-band line x centroid; band 0 in LSBs, band 0 is the top rows.
- band_valid, output, BANDS, per-band centroid valid.
- result_valid, output, 1, one-cycle pulse when outputs update.
- busy, output, 1, divide sequence in progress.
- overrun, output, 1, one-cycle pulse when a frame_done is dropped.

Function
REQ-003 SHALL keep internal col (9b) and row (8b) counters; when pix_valid is high, col increments and wraps to 0 at IMG_W-1, and row increments on wrap.
REQ-004 SHALL force col=0 and row=0 for any pix_valid with pix_addr==0, so that pixel is accumulated as (0,0).
REQ-005 SHALL, on pix_valid && pix_bit with row<IMG_H, add col to sum[band] (23b) and 1 to cnt[band] (15b), where band=row/(IMG_H/BANDS); rows at or beyond IMG_H SHALL be ignored.
REQ-006 SHALL, on frame_done while not busy, snapshot sum/cnt into divide registers, clear the accumulators and counters the same cycle, and assert busy the next cycle.
REQ-007 SHALL include a pixel that arrives in the same cycle as frame_done in the snapshot.
REQ-008 SHALL, on frame_done while busy, discard the snapshot, clear the accumulators and counters, pulse overrun, and leave the in-progress results undisturbed.
REQ-009 SHALL use FSM states IDLE→LOAD→DIV(23 cycles)→STORE, repeating LOAD/DIV/STORE per band 0..BANDS-1, then DONE→IDLE.
REQ-010 SHALL compute centroid = floor(sum/cnt), 23-bit restoring division at 1 quotient bit per cycle, truncated to 9 bits.
REQ-011 SHALL, for cnt==0, still spend the full DIV time, store centroid 0, and clear band_valid.
REQ-012 SHALL update centroid_x and band_valid only in DONE, pulse result_valid for exactly one cycle in DONE, and hold all outputs until the next DONE.
REQ-013 SHALL pulse result_valid exactly BANDS*25+1 cycles after the frame_done cycle (101 for defaults).
REQ-014 SHALL keep busy high from the cycle after frame_done through DONE inclusive.

Reset
REQ-015 SHALL, with nreset low, asynchronously clear counters, accumulators, the divider, centroid_x, band_valid, result_valid, busy, and overrun, and return the FSM to IDLE.
REQ-016 SHALL, on reset mid-divide, discard partial results; no result_valid until a full new sequence completes.

Configuration
REQ-017 SHALL, with LINE_TRACK_MINCOUNT_EN defined, set band_valid only when cnt>=MIN_PIXELS.
REQ-018 SHALL, without LINE_TRACK_MINCOUNT_EN, set band_valid when cnt>0, and MIN_PIXELS SHALL be unused.

Structure
REQ-019 SHALL take IMG_W/IMG_H defaults, the sum/count/centroid widths, the divide cycle count (23), and the FSM state enum from shared package line_track_pkg.
REQ-020 SHALL implement division in sub-module line_track_divider (start/done handshake, 23-cycle fixed latency).

Verification
REQ-021 Full frame, band0 pixels set at cols 100..109 on every row, other bands empty -> centroid band0=104, band_valid=4'b0001, result_valid at frame_done+101.
REQ-022 Single set pixel (col 319,row 239) -> band3 centroid 319, band_valid=4'b1000 without macro, 4'b0000 with LINE_TRACK_MINCOUNT_EN.
REQ-023 Second frame_done 50 cycles after first -> overrun pulse, first frame's results still delivered at +101, no second result_valid.
REQ-024 nreset pulsed at frame_done+40 -> all outputs 0, busy 0, no result_valid; next full frame produces correct results.
REQ-025 pix_addr==0 injected mid-frame at col 57 -> counters realign, pixel at (0,0) accumulated into band0, centroids match the realigned reference.
REQ-026 Pixel with pix_bit=1 at col 200 coincident with the frame_done cycle, band2 otherwise empty -> pixel counted in the closing frame (band2 centroid 200), and the next frame starts with cleared accumulators.
